// File: rtl/uc_sequencer_if.sv
// Memory bus between the uc_sequencer control unit and its synchronous
// single-port memory. The sequencer is the master: it drives address,
// access strobe and write strobe, and receives read data one cycle after
// a read access. Write data is not part of this bus; it comes straight
// from the UT accumulator.
//
// Bus protocol: mem_en=1 requests an access at mem_addr in that cycle.
// With mem_we=0, mem_rdata carries the addressed word in the following
// cycle. With mem_we=1, the word is written at the clock edge. There is
// no back-pressure; the memory must accept every access.
interface uc_sequencer_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_en,
    output mem_we,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_en,
    input  mem_we,
    output mem_rdata
  );
endinterface

// File: rtl/uc_sequencer.sv
// uc_sequencer: control unit of a 4-instruction accumulator processor.
// Owns PC and RI, drives the memory bus and every UT datapath strobe.
// Instruction word: opcode = word[ADDR_W+1:ADDR_W], operand = word[ADDR_W-1:0].
// Opcodes: 00 NOR, 01 ADD, 10 STA, 11 JCC (jump when carry clear).
// Outputs are a Moore decode of the state, with every strobe gated by ce.
// Optional build macro UC_STEP_EN adds a 'step' input: the FSM waits in
// FETCH_INS until step is seen, then runs exactly one instruction.
module uc_sequencer #(
  parameter int          ADDR_W  = 6,
  parameter int          DATA_W  = 8,
  parameter logic [2:0]  SEL_NOR = 3'b000,
  parameter logic [2:0]  SEL_ADD = 3'b001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
`ifdef UC_STEP_EN
  input  logic              step,
`endif
  input  logic              carry,
  uc_sequencer_if.master    mem,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_done,
  output logic [2:0]        state_dbg
);

  // The instruction word must hold a 2-bit opcode above a full address.
  if (DATA_W < ADDR_W + 2) begin : g_bad_width
    $error("uc_sequencer: DATA_W must be at least ADDR_W+2");
  end

  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_FETCH_INS = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_OP  = 3'd3,
    S_LOAD_R1   = 3'd4,
    S_EXE       = 3'd5,
    S_STORE     = 3'd6,
    S_EXE_JCC   = 3'd7
  } state_t;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W+1:0]   ri_q, ri_d;

  // Ungated strobes straight from the state decode.
  logic                en_s, we_s, lr1_s, la_s, lc_s, ic_s, done_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [2:0]          sel_s;

  logic [1:0]          ri_op;
  logic [ADDR_W-1:0]   ri_operand;
  logic [1:0]          rd_op;

  assign ri_op      = ri_q[ADDR_W+1:ADDR_W];
  assign ri_operand = ri_q[ADDR_W-1:0];
  // DECODE steers on the word arriving from memory, RI is loaded in parallel.
  assign rd_op      = mem.mem_rdata[ADDR_W+1:ADDR_W];

  // State, PC and RI registers: reset wins, ce=0 freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ri_q    <= '0;
    end else if (ce) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ri_q    <= ri_d;
    end
  end

  // Next-state, PC/RI update and Moore strobe decode.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ri_d    = ri_q;
    addr_s  = pc_q;
    sel_s   = SEL_NOR;
    en_s    = 1'b0;
    we_s    = 1'b0;
    lr1_s   = 1'b0;
    la_s    = 1'b0;
    lc_s    = 1'b0;
    ic_s    = 1'b0;
    done_s  = 1'b0;
    case (state_q)
      S_INIT: begin
        ic_s    = 1'b1;
        state_d = S_FETCH_INS;
      end
      S_FETCH_INS: begin
`ifdef UC_STEP_EN
        // Hold here, bus idle, until a step request arrives.
        if (step) begin
          en_s    = 1'b1;
          state_d = S_DECODE;
        end
`else
        en_s    = 1'b1;
        state_d = S_DECODE;
`endif
      end
      S_DECODE: begin
        ri_d = mem.mem_rdata[ADDR_W+1:0];
        pc_d = pc_q + ADDR_W'(1);
        case (rd_op)
          OP_NOR, OP_ADD: state_d = S_FETCH_OP;
          OP_STA:         state_d = S_STORE;
          default:        state_d = S_EXE_JCC;
        endcase
      end
      S_FETCH_OP: begin
        en_s    = 1'b1;
        addr_s  = ri_operand;
        state_d = S_LOAD_R1;
      end
      S_LOAD_R1: begin
        // Operand word is on mem_rdata now; UT captures it into R1.
        lr1_s   = 1'b1;
        state_d = S_EXE;
      end
      S_EXE: begin
        la_s   = 1'b1;
        done_s = 1'b1;
        // NOR leaves the carry flag untouched.
        if (ri_op == OP_ADD) begin
          sel_s = SEL_ADD;
          lc_s  = 1'b1;
        end
        state_d = S_FETCH_INS;
      end
      S_STORE: begin
        en_s    = 1'b1;
        we_s    = 1'b1;
        addr_s  = ri_operand;
        done_s  = 1'b1;
        state_d = S_FETCH_INS;
      end
      S_EXE_JCC: begin
        // carry is read here before init_carry clears it at this edge.
        ic_s   = 1'b1;
        done_s = 1'b1;
        if (!carry) begin
          pc_d = ri_operand;
        end
        state_d = S_FETCH_INS;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign mem.mem_addr = addr_s;
  assign mem.mem_en   = ce & en_s;
  assign mem.mem_we   = ce & we_s;
  assign sel_UAL      = sel_s;
  assign load_R1      = ce & lr1_s;
  assign load_accu    = ce & la_s;
  assign load_carry   = ce & lc_s;
  assign init_carry   = ce & ic_s;
  assign instr_done   = ce & done_s;
  assign pc           = pc_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_uc_sequencer.sv
// Directed bench for uc_sequencer. Expected per-cycle output vectors are
// queued as each step is set up and popped one per clock for comparison.
module tb_uc_sequencer;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam logic [2:0] NOR = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam int VW = 22;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic ce;
  logic carry;
`ifdef UC_STEP_EN
  logic step;
`endif
  always #5 clk = ~clk;

  logic [2:0]    sel_UAL;
  logic          load_R1, load_accu, load_carry, init_carry, instr_done;
  logic [AW-1:0] pc;
  logic [2:0]    state_dbg;

  uc_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  uc_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
`ifdef UC_STEP_EN
    .step       (step),
`endif
    .carry      (carry),
    .mem        (bus.master),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .init_carry (init_carry),
    .pc         (pc),
    .instr_done (instr_done),
    .state_dbg  (state_dbg)
  );

  // memory model: synchronous read, writes only recorded
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] last_wr_addr;
  int            wr_count;
  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_en && bus.mem_we) begin
      last_wr_addr <= bus.mem_addr;
      wr_count     <= wr_count + 1;
    end
  end

  // scoreboard
  logic [VW-1:0] exp_q[$];
  string         tag_q[$];
  int            checks = 0;
  int            failures = 0;

  function automatic logic [VW-1:0] mk(input logic en, input logic we,
      input logic [AW-1:0] a, input logic [2:0] sel, input logic lr1,
      input logic la, input logic lc, input logic ic, input logic dn,
      input logic [AW-1:0] p);
    return {en, we, a, sel, lr1, la, lc, ic, dn, p};
  endfunction

  task automatic push(input logic [VW-1:0] v, input string t);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic push_init();
    push(mk(1'b0, 1'b0, 6'd0, NOR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0), "init");
  endtask

  task automatic push_fetch(input logic [AW-1:0] p);
    push(mk(1'b1, 1'b0, p, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p), "fetch");
    push(mk(1'b0, 1'b0, p, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p), "decode");
  endtask

  task automatic push_op_fetch(input logic [AW-1:0] n, input logic [AW-1:0] op);
    push(mk(1'b1, 1'b0, op, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, n), "fetch_op");
  endtask

  task automatic push_load_exe(input logic [AW-1:0] n, input logic add);
    push(mk(1'b0, 1'b0, n, NOR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, n), "load_r1");
    push(mk(1'b0, 1'b0, n, add ? ADD : NOR, 1'b0, 1'b1, add, 1'b0, 1'b1, n),
         add ? "exe_add" : "exe_nor");
  endtask

  task automatic push_alu(input logic [AW-1:0] p, input logic [AW-1:0] op, input logic add);
    logic [AW-1:0] n;
    n = p + 6'd1;
    push_fetch(p);
    push_op_fetch(n, op);
    push_load_exe(n, add);
  endtask

  task automatic push_sta(input logic [AW-1:0] p, input logic [AW-1:0] a);
    logic [AW-1:0] n;
    n = p + 6'd1;
    push_fetch(p);
    push(mk(1'b1, 1'b1, a, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, n), "store");
  endtask

  task automatic push_jcc(input logic [AW-1:0] p);
    logic [AW-1:0] n;
    n = p + 6'd1;
    push_fetch(p);
    push(mk(1'b0, 1'b0, n, NOR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, n), "exe_jcc");
  endtask

  task automatic push_frozen(input logic [AW-1:0] p);
    push(mk(1'b0, 1'b0, p, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, p), "ce_hold");
  endtask

  // Called at a falling edge with inputs already set; checks n cycles.
  task automatic run_cycles(input int n);
    logic [VW-1:0] obs, exp_v;
    string t;
    for (int i = 0; i < n; i++) begin
      #1;
      obs = {bus.mem_en, bus.mem_we, bus.mem_addr, sel_UAL, load_R1, load_accu,
             load_carry, init_carry, instr_done, pc};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $error("FAIL scoreboard_underflow obs=%h exp=none", obs);
      end else begin
        exp_v = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === exp_v) else begin
          failures++;
          $error("FAIL %s pc=%0h obs=%h exp=%h", t, pc, obs, exp_v);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[6'h00] = 8'h45;   // ADD 0x05
    mem[6'h01] = 8'h0A;   // NOR 0x0A
    mem[6'h02] = 8'h8F;   // STA 0x0F
    mem[6'h03] = 8'hD0;   // JCC 0x10
    mem[6'h04] = 8'h45;   // ADD 0x05
    mem[6'h05] = 8'h03;   // NOR 0x03 (also operand data)
    mem[6'h06] = 8'hFF;   // JCC 0x3F
    mem[6'h10] = 8'hD0;   // JCC 0x10: halt loop
    mem[6'h3F] = 8'h8E;   // STA 0x0E
    wr_count      = 0;
    last_wr_addr  = '0;
    bus.mem_rdata = '0;
    ce    = 1'b1;
    carry = 1'b0;
`ifdef UC_STEP_EN
    step  = 1'b1;
`endif
    rst   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset, ADD, NOR, STA, JCC taken, halt loop
    push_init();
    push_alu(6'h00, 6'h05, 1'b1);
    push_alu(6'h01, 6'h0A, 1'b0);
    push_sta(6'h02, 6'h0F);
    push_jcc(6'h03);
    push_jcc(6'h10);
    push(mk(1'b1, 1'b0, 6'h10, NOR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'h10), "halt_refetch");
    run_cycles(exp_q.size());

    checks++;
    assert (last_wr_addr === 6'h0F && wr_count === 1) else begin
      failures++;
      $error("FAIL sta_write obs=%0h/%0d exp=0f/1", last_wr_addr, wr_count);
    end

    // JCC not taken with carry=1, then ce freeze in LOAD_R1
    do_reset();
    carry = 1'b1;
    push_init();
    push_alu(6'h00, 6'h05, 1'b1);
    push_alu(6'h01, 6'h0A, 1'b0);
    push_sta(6'h02, 6'h0F);
    push_jcc(6'h03);
    push_fetch(6'h04);
    push_op_fetch(6'h05, 6'h05);
    run_cycles(exp_q.size());
    ce = 1'b0;
    repeat (3) push_frozen(6'h05);
    run_cycles(3);
    ce = 1'b1;
    push_load_exe(6'h05, 1'b1);
    run_cycles(2);

    // NOR, JCC to 0x3F, STA at 0x3F wraps PC to 0
    carry = 1'b0;
    push_alu(6'h05, 6'h03, 1'b0);
    push_jcc(6'h06);
    push_sta(6'h3F, 6'h0E);
    push_fetch(6'h00);
    push_op_fetch(6'h01, 6'h05);
    run_cycles(exp_q.size());

    checks++;
    assert (last_wr_addr === 6'h0E && wr_count === 3) else begin
      failures++;
      $error("FAIL sta_wrap_write obs=%0h/%0d exp=0e/3", last_wr_addr, wr_count);
    end

    // reset asserted during LOAD_R1 forces INIT at the next edge
    rst = 1'b1;
    push(mk(1'b0, 1'b0, 6'h01, NOR, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'h01), "load_r1_rst");
    run_cycles(1);
    rst = 1'b0;
    push_init();
    push_fetch(6'h00);
    run_cycles(exp_q.size());

    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL queue_drain obs=%0d exp=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
